// File: rtl/piso_register.sv
// Parallel-in serial-out shifter, LSB first; bit k appears k+1 cycles after the accepting edge.
// load_ready is high when idle or while the last bit is out, so a held load_valid streams gap-free.
module piso_register #(
    parameter int   WIDTH      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             done
);
    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh;
    logic             last_bit;
    logic             accept;

    // cnt tracks which bit index is currently on out
    assign last_bit   = (state == SHIFT) && (cnt == LAST);
    assign load_ready = (state == IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            out       <= IDLE_LEVEL;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else if (accept) begin
            state     <= SHIFT;
            cnt       <= '0;
            sh        <= load_data >> 1;
            out       <= load_data[0];
            out_valid <= 1'b1;
            done      <= 1'b0;
        end else if (state == SHIFT) begin
            if (last_bit) begin
                state     <= IDLE;
                cnt       <= '0;
                out       <= IDLE_LEVEL;
                out_valid <= 1'b0;
                done      <= 1'b0;
            end else begin
                cnt  <= cnt + CW'(1);
                sh   <= sh >> 1;
                out  <= sh[0];
                done <= (cnt == PENULT);
            end
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_register.sv
// Scoreboarded bench for piso_register at WIDTH=4/IDLE_LEVEL=0 and WIDTH=8/IDLE_LEVEL=1.
module tb_piso_register;
    typedef struct {
        bit       b;
        bit       last;
        bit [7:0] word;
    } bit_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lv4 = 1'b0, lv8 = 1'b0;
    logic [3:0] ld4 = '0;
    logic [7:0] ld8 = '0;
    logic       rdy4, out4, vld4, done4;
    logic       rdy8, out8, vld8, done8;

    int vectors = 0;
    int miscompares = 0;

    // Expected serial bits; front entry is the bit that should be on out right now
    bit_t q4[$];
    bit_t q8[$];
    logic [3:0] rx4 = '0;
    logic [7:0] rx8 = '0;

    always #5 clk = ~clk;

    piso_register #(.WIDTH(4), .IDLE_LEVEL(1'b0)) dut4 (
        .clk(clk), .rst(rst), .load_valid(lv4), .load_data(ld4),
        .load_ready(rdy4), .out(out4), .out_valid(vld4), .done(done4)
    );

    piso_register #(.WIDTH(8), .IDLE_LEVEL(1'b1)) dut8 (
        .clk(clk), .rst(rst), .load_valid(lv8), .load_data(ld8),
        .load_ready(rdy8), .out(out8), .out_valid(vld8), .done(done8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a word is taken whenever at most its predecessor's final bit is still pending
    always @(posedge clk) begin
        bit r4, r8;
        if (rst) begin
            r4 = (q4.size() <= 1);
            r8 = (q8.size() <= 1);
            if (q4.size() > 0) void'(q4.pop_front());
            if (q8.size() > 0) void'(q8.pop_front());
            if (lv4 && r4)
                for (int k = 0; k < 4; k++) q4.push_back('{ld4[k], k == 3, {4'h0, ld4}});
            if (lv8 && r8)
                for (int k = 0; k < 8; k++) q8.push_back('{ld8[k], k == 7, ld8});
        end
    end

    always @(negedge rst) begin
        q4.delete();
        q8.delete();
    end

    always @(negedge clk) begin
        bit_t e;
        chk("ready4", rdy4, q4.size() <= 1);
        if (q4.size() > 0) begin
            e = q4[0];
            chk("valid4", vld4, 1);
            chk("out4", out4, e.b);
            chk("done4", done4, e.last);
            rx4 = {out4, rx4[3:1]};
            if (e.last) chk("rx4", rx4, e.word);
        end else begin
            chk("valid4", vld4, 0);
            chk("idle_out4", out4, 0);
            chk("done4", done4, 0);
        end
        chk("ready8", rdy8, q8.size() <= 1);
        if (q8.size() > 0) begin
            e = q8[0];
            chk("valid8", vld8, 1);
            chk("out8", out8, e.b);
            chk("done8", done8, e.last);
            rx8 = {out8, rx8[7:1]};
            if (e.last) chk("rx8", rx8, e.word);
        end else begin
            chk("valid8", vld8, 0);
            chk("idle_out8", out8, 1);
            chk("done8", done8, 0);
        end
    end

    task automatic put4(input logic [3:0] d);
        bit r;
        lv4 = 1'b1;
        ld4 = d;
        for (int i = 0; i < 64; i++) begin
            r = (q4.size() <= 1) && rst;
            step();
            if (r) return;
        end
        chk("put4_timeout", 0, 1);
    endtask

    task automatic put8(input logic [7:0] d);
        bit r;
        lv8 = 1'b1;
        ld8 = d;
        for (int i = 0; i < 64; i++) begin
            r = (q8.size() <= 1) && rst;
            step();
            if (r) return;
        end
        chk("put8_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        lv4 = 1'b0;
        lv8 = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset held with load_valid asserted: nothing may be accepted
        lv4 = 1'b1; ld4 = 4'hB;
        lv8 = 1'b1; ld8 = 8'hFF;
        #1;
        step(); step();
        lv4 = 1'b0; lv8 = 1'b0;
        rst = 1'b1;
        idle(2);

        put4(4'b1011);
        idle(6);

        put4(4'hA);
        put4(4'h5);
        idle(6);

        // Busy load: offered while cnt==1, must be ignored
        put4(4'hC);
        lv4 = 1'b0;
        step();
        lv4 = 1'b1; ld4 = 4'hF;
        #1 chk("busy_ready4", rdy4, 0);
        step();
        lv4 = 1'b0;
        idle(6);

        // Asynchronous reset mid-word
        put4(4'hF);
        lv4 = 1'b0;
        step();
        #2 rst = 1'b0;
        #1;
        chk("async_valid4", vld4, 0);
        chk("async_out4", out4, 0);
        chk("async_out8", out8, 1);
        step();
        rst = 1'b1;
        put4(4'h1);
        idle(6);

        put8(8'h81);
        idle(10);

        for (int i = 0; i < 400; i++) begin
            lv4 = ($urandom_range(0, 3) != 0);
            ld4 = 4'($urandom);
            lv8 = ($urandom_range(0, 3) != 0);
            ld8 = 8'($urandom);
            step();
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/piso_register.md
# piso_register

Parallel-in, serial-out shift register: the transmit end of the team's serial-in right-shift register chain. Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock, LSB first. A downstream right-shift register that takes its serial input at its MSB holds the original word after WIDTH shifts. Back-to-back words stream with no gap cycles.

## Interface
- WIDTH, 4, word width in bits; legal range is WIDTH >= 2.
- IDLE_LEVEL, 1'b0, value driven on `out` whenever no bit is being transmitted.

- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- load_valid  input  1  `load_data` is offered for transmission.
- load_data  input  WIDTH  word to serialize.
- load_ready  output  1  block can accept a word this cycle.
- out  output  1  serial data bit, registered.
- out_valid  output  1  `out` carries a data bit this cycle, registered.
- done  output  1  single-cycle pulse while the last bit of a word is on `out`, registered.

## Operation
- Storage: shift register `sh[WIDTH-1:0]`; bit counter `cnt` of width $clog2(WIDTH); state in {IDLE, SHIFT}.
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, sh=0.
  - out=IDLE_LEVEL, out_valid=0, done=0.
  - load_ready=1 as soon as reset is released.
- load_ready is combinational: 1 in IDLE, or in SHIFT when cnt==WIDTH-1; 0 otherwise.
- Accept: a word is accepted on a rising edge with load_valid && load_ready. At that edge:
  - out <= load_data[0], out_valid <= 1.
  - sh <= load_data >> 1, cnt <= 0, state <= SHIFT.
- SHIFT with cnt < WIDTH-1, each edge:
  - out <= sh[0], sh <= sh >> 1, cnt <= cnt+1.
- SHIFT with cnt == WIDTH-1 (last bit is on `out`):
  - done=1 during this cycle.
  - If a load is accepted at the closing edge, reload as in Accept; state stays SHIFT.
  - Otherwise state <= IDLE, out <= IDLE_LEVEL, out_valid <= 0.
- done is registered: it is set on the edge that puts bit WIDTH-1 on `out`, and cleared on the next edge.
- load_valid while load_ready=0 is ignored. load_data is not sampled and there is no error flag. The upstream holds the word until the handshake completes.
- load_data is sampled only at the accepting edge; later changes do not affect the word in flight.

## Timing
- Latency: bit k of the accepted word is on `out` during cycle k+1 after the accepting edge (k = 0..WIDTH-1).
- A word occupies exactly WIDTH cycles of out_valid=1.
- Continuous stream: load_valid held at 1 yields out_valid=1 every cycle. Word n+1 bit 0 follows word n bit WIDTH-1 directly.
- Throughput: one word per WIDTH cycles.
- Reset asserted mid-word: outputs go to reset values immediately, asynchronously. The partial word is discarded, not resumed.
- Reset released: the first accept is possible at the first rising edge with rst=1.

## Test plan
- Reset:
  - Stimulus: hold rst=0 for 2 cycles with load_valid=1.
  - Required: out=0, out_valid=0, done=0, load_ready=1, and no word accepted.
- Single word, WIDTH=4:
  - Stimulus: load 4'b1011 for one cycle.
  - Required: out = 1,1,0,1 on the next 4 cycles with out_valid=1. done=1 only in the 4th cycle. Then out=0, out_valid=0.
  - Required: a serial-in right-shift register fed from `out` reads 4'b1011.
- Back-to-back:
  - Stimulus: load_valid=1 continuously with 4'hA then 4'h5.
  - Required: out = 0,1,0,1,1,0,1,0. out_valid=1 for all 8 cycles. done=1 in cycles 4 and 8.
- Busy load ignored:
  - Stimulus: load 4'hC, then pulse load_valid with 4'hF while cnt=1.
  - Required: load_ready=0 during the pulse. Output remains 0,0,1,1. 4'hF is never transmitted.
- Reset mid-shift:
  - Stimulus: load 4'hF, assert rst=0 between edges after bit 1.
  - Required: out_valid and out go to 0 immediately, without waiting for an edge.
  - Required: after release, a new load of 4'h1 transmits 1,0,0,0.
- WIDTH=8, IDLE_LEVEL=1:
  - Stimulus: load 8'h81.
  - Required: out = 1,0,0,0,0,0,0,1. done=1 in cycle 8. out=1 while idle and in reset.
